cam_dvp_rgb888_tx: RTL
======================

# cam_dvp_rgb888_tx

Camera-side source for the pixel-clock domain. Converts the raw 8-bit DVP bus (RGB565, two bytes per pixel) into the single-cycle `o_cam_de` / `o_cam_vsync` / `o_cam_data_rgb888` stream consumed by the frame buffer / MJPEG path. The block gates whole frames on request from downstream, so only complete frames enter the MJPEG/DDR3 pipeline. It also discards the sensor's start-up frames.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line forwarded.
- V_ACTIVE, 480, lines per frame forwarded.
- SKIP_FRAMES, 10, sensor frames discarded after reset (0 allowed).
- VSYNC_POL, 1, DVP vsync active level (1 = high).

Ports (reset rst_n, asynchronous, active-low; clock i_cam_rgb888_pclk):
- i_cam_rgb888_pclk  in  1  DVP pixel clock; all logic on rising edge.
- rst_n  in  1  async active-low reset.
- i_dvp_vsync  in  1  sensor vsync, already synchronous to pclk.
- i_dvp_href  in  1  line valid.
- i_dvp_data  in  8  RGB565 byte stream; first byte {R[4:0],G[5:3]}, second byte {G[2:0],B[4:0]}.
- i_frame_req  in  1  one-cycle pulse; downstream ready for one frame.
- o_cam_vsync  out  1  one-cycle frame-start pulse (forwarded frames only).
- o_cam_de  out  1  one-cycle pixel valid.
- o_cam_data_rgb888  out  24  {R8,G8,B8}.
- o_frame_done  out  1  one-cycle pulse at end of forwarded frame.
- o_line_err  out  1  sticky line-length/odd-byte error for current frame.
- o_frame_cnt  out  16  completed forwarded frames, wraps 0xFFFF→0.

## Operation
- Input stage: vsync, href, and data are registered once. Vsync start = inactive→active edge of the registered vsync (per VSYNC_POL).
- States:
  - S_SKIP: count vsync starts. When the count reaches SKIP_FRAMES, go to S_IDLE. SKIP_FRAMES=0 enters S_IDLE directly after reset.
  - S_IDLE: wait until req_pending=1, then go to S_ARMED.
  - S_ARMED: wait for a vsync start. On it: pulse o_cam_vsync, clear req_pending, clear o_line_err, zero the line/pixel counters, go to S_FRAME.
  - S_FRAME: forward pixels. Exit on either (a) the falling edge of href on line V_ACTIVE, or (b) a vsync start. On exit: pulse o_frame_done, increment o_frame_cnt, go to S_IDLE. In case (b), also set o_line_err if line_cnt < V_ACTIVE; this vsync start is not reused to open a new frame.
- req_pending:
  - Set by i_frame_req in any state, including S_SKIP and S_FRAME.
  - Cleared only on entry to S_FRAME.
  - Multiple requests collapse into one pending request.
- Byte pairing:
  - The phase bit clears on every href rising edge and toggles on each href-high byte.
  - On the second byte, emit one pixel if pix_cnt < H_ACTIVE and line_cnt < V_ACTIVE.
  - Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Line end (href falling edge in S_FRAME):
  - If pix_cnt ≠ H_ACTIVE or phase is odd, set o_line_err. A dangling odd byte is dropped.
  - Then increment line_cnt (saturates at V_ACTIVE) and reset pix_cnt.
- Outside S_FRAME no pixels are emitted, but byte pairing still tracks href.

## Timing
- Reset values: o_cam_vsync=0, o_cam_de=0, o_cam_data_rgb888=0, o_frame_done=0, o_line_err=0, o_frame_cnt=0. Internal: state=S_SKIP, req_pending=0, all counters 0.
- Pixel latency: the second byte appears on i_dvp_data at edge k. o_cam_de=1 with the pixel data after edge k+2 (input register, then output register). It is high for exactly one cycle, at most every 2 cycles.
- o_cam_data_rgb888 holds its last pixel when o_cam_de=0.
- o_cam_vsync is asserted 2 cycles after the vsync edge on the pins, and at least 2 cycles before the first o_cam_de of the frame.
- o_frame_done is asserted 2 cycles after the terminating href fall or vsync edge. o_frame_cnt updates in the same cycle.
- Simultaneous events:
  - A vsync start in S_ARMED in the same cycle as i_frame_req: the frame opens, and req_pending ends at 0.
  - i_frame_req in the cycle of o_frame_done: stays pending.
- Reset mid-frame: all outputs drop to reset values on the next evaluation (asynchronous). The skip count restarts.

## Test plan
- Setup for all scenarios: H_ACTIVE=4, V_ACTIVE=2, SKIP_FRAMES=1.
- Skip/gating: apply 2 sensor frames with i_frame_req pulsed before the first. Required: frame 1 is skipped. Frame 2 gives 1 o_cam_vsync, 8 o_cam_de, 1 o_frame_done, o_frame_cnt=1.
- Pixel conversion: byte pairs 0xF8,0x00 / 0x07,0xE0 / 0x00,0x1F / 0xFF,0xFF. Required outputs: 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF, each 2 cycles after its second byte.
- No request: 3 frames without i_frame_req. Required: no o_cam_de, o_cam_vsync, or o_frame_done; o_frame_cnt=0. Then a request mid-frame: the next full frame is forwarded.
- Line errors: a line of 5 bytes (odd), and a line of 6 pixels. Required: odd case gives 2 pixels and o_line_err=1; long case gives 4 pixels (extra 2 suppressed) and o_line_err=1. The flag clears at the next forwarded o_cam_vsync.
- Short frame: vsync arrives after 1 line. Required: o_frame_done pulse, o_line_err=1, state S_IDLE, and that vsync does not start a frame even with a request pending.
- Reset mid-frame: assert rst_n=0 during pixel 3. Required: all outputs 0 immediately, o_frame_cnt=0, and the next frame is skipped (SKIP_FRAMES=1).

Source files
------------

// File: rtl/cam_dvp_rgb888_tx.sv
// DVP RGB565 byte stream to a gated, frame-aligned RGB888 pixel stream.
// Drops start-up frames and forwards one whole frame per downstream request.
module cam_dvp_rgb888_tx #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SKIP_FRAMES = 10,
   parameter bit VSYNC_POL   = 1'b1
) (
   input  logic        i_cam_rgb888_pclk,
   input  logic        rst_n,
   input  logic        i_dvp_vsync,
   input  logic        i_dvp_href,
   input  logic [7:0]  i_dvp_data,
   input  logic        i_frame_req,
   output logic        o_cam_vsync,
   output logic        o_cam_de,
   output logic [23:0] o_cam_data_rgb888,
   output logic        o_frame_done,
   output logic        o_line_err,
   output logic [15:0] o_frame_cnt
);

   localparam int PW = $clog2(H_ACTIVE + 2);
   localparam int LW = $clog2(V_ACTIVE + 1);
   localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
   localparam int SL = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;

   localparam logic [PW-1:0] H_MAX  = PW'(H_ACTIVE);
   localparam logic [PW-1:0] H_SAT  = PW'(H_ACTIVE + 1);
   localparam logic [LW-1:0] V_MAX  = LW'(V_ACTIVE);
   localparam logic [LW-1:0] V_LAST = LW'(V_ACTIVE - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SL);

   typedef enum logic [1:0] {
      S_SKIP,
      S_IDLE,
      S_ARMED,
      S_FRAME
   } state_t;

   state_t state, state_nxt;

   logic          vs_r, vs_rr;
   logic          href_r, href_rr;
   logic [7:0]    data_r, byte0;
   logic          phase;
   logic [PW-1:0] pix_cnt;
   logic [LW-1:0] line_cnt;
   logic [SW-1:0] skip_cnt;
   logic          req_pending;

   logic vs_start, href_rise, href_fall;
   logic cur_phase, second, in_frame;
   logic pix_ok, line_end, open_frm;
   logic close_a, close_b, close_frm;
   logic [4:0] r5, b5;
   logic [5:0] g6;

   always_ff @(posedge i_cam_rgb888_pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_r    <= ~VSYNC_POL;
         vs_rr   <= ~VSYNC_POL;
         href_r  <= 1'b0;
         href_rr <= 1'b0;
         data_r  <= 8'd0;
      end else begin
         vs_r    <= i_dvp_vsync;
         vs_rr   <= vs_r;
         href_r  <= i_dvp_href;
         href_rr <= href_r;
         data_r  <= i_dvp_data;
      end
   end

   assign vs_start  = (vs_r == VSYNC_POL) && (vs_rr != VSYNC_POL);
   assign href_rise = href_r & ~href_rr;
   assign href_fall = ~href_r & href_rr;
   // a new line always starts on the first byte of a pair
   assign cur_phase = href_rise ? 1'b0 : phase;
   assign second    = href_r & cur_phase;
   assign in_frame  = (state == S_FRAME);

   assign pix_ok    = in_frame & second &
                      (pix_cnt < H_MAX) & (line_cnt < V_MAX);
   assign line_end  = in_frame & href_fall;
   assign open_frm  = (state == S_ARMED) & vs_start;
   assign close_a   = line_end & (line_cnt == V_LAST);
   assign close_b   = in_frame & vs_start;
   assign close_frm = close_a | close_b;

   assign r5 = byte0[7:3];
   assign g6 = {byte0[2:0], data_r[7:5]};
   assign b5 = data_r[4:0];

   always_ff @(posedge i_cam_rgb888_pclk or negedge rst_n) begin
      if (!rst_n) state <= S_SKIP;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_SKIP:
            if (SKIP_FRAMES == 0 ||
                (vs_start && skip_cnt == S_LAST))
               state_nxt = S_IDLE;
         S_IDLE:
            if (req_pending) state_nxt = S_ARMED;
         S_ARMED:
            if (vs_start) state_nxt = S_FRAME;
         S_FRAME:
            if (close_frm) state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_cam_rgb888_pclk or negedge rst_n) begin
      if (!rst_n) begin
         phase       <= 1'b0;
         byte0       <= 8'd0;
         skip_cnt    <= '0;
         req_pending <= 1'b0;
      end else begin
         if (href_r) phase <= ~cur_phase;
         if (href_r && !cur_phase) byte0 <= data_r;
         if (state == S_SKIP && vs_start)
            skip_cnt <= skip_cnt + 1'b1;
         // opening a frame consumes the request, even one arriving now
         if (open_frm)         req_pending <= 1'b0;
         else if (i_frame_req) req_pending <= 1'b1;
      end
   end

   always_ff @(posedge i_cam_rgb888_pclk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt  <= '0;
         line_cnt <= '0;
      end else if (open_frm) begin
         pix_cnt  <= '0;
         line_cnt <= '0;
      end else if (line_end) begin
         pix_cnt  <= '0;
         if (line_cnt != V_MAX) line_cnt <= line_cnt + 1'b1;
      end else if (in_frame && second && pix_cnt != H_SAT) begin
         pix_cnt  <= pix_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_cam_rgb888_pclk or negedge rst_n) begin
      if (!rst_n) begin
         o_cam_vsync       <= 1'b0;
         o_cam_de          <= 1'b0;
         o_cam_data_rgb888 <= 24'd0;
         o_frame_done      <= 1'b0;
         o_line_err        <= 1'b0;
         o_frame_cnt       <= 16'd0;
      end else begin
         o_cam_vsync  <= open_frm;
         o_cam_de     <= pix_ok;
         o_frame_done <= close_frm;
         if (pix_ok)
            o_cam_data_rgb888 <= {r5, r5[4:2], g6, g6[5:4],
                                  b5, b5[4:2]};
         if (close_frm) o_frame_cnt <= o_frame_cnt + 16'd1;
         if (open_frm)
            o_line_err <= 1'b0;
         else if (line_end && (pix_cnt != H_MAX || phase))
            o_line_err <= 1'b1;
         else if (close_b && line_cnt < V_MAX)
            o_line_err <= 1'b1;
      end
   end

endmodule
